rbc_counter: RTL
================

Name: rbc_counter

Overview:
- Synchronous up/down counter whose state is presented as Reflected Binary Code (Gray code). A binary copy of the state is output alongside it.
- Feeds the Gray-to-binary converter stage and any consumer that needs one-bit-per-step transitions, such as pointer crossings and position encoders.
- Load value is accepted in Gray code and converted internally.
- All outputs are registered; no combinational path runs from inputs to outputs.

Parameters:
- p_WIDTH, 4: counter and io vector width; MUST BE greater than zero.
- p_WRAP, 1: 1 = wrap at the ends of the range; 0 = saturate at the ends of the range.

Ports:
- iw_clk  input  1  clock; all state changes on the rising edge.
- iw_rst  input  1  reset, synchronous, active-high.
- iw_en  input  1  count enable; one step per cycle while high.
- iw_up  input  1  direction: 1 = increment, 0 = decrement; sampled only when iw_en is high.
- iw_load  input  1  load strobe.
- iwv_load_rbc  input  p_WIDTH  load value in Gray code; sampled when iw_load is high.
- owv_rbc  output  p_WIDTH  counter state, Gray code.
- owv_bin  output  p_WIDTH  counter state, binary; always equals the Gray-to-binary decode of owv_rbc.
- ow_tc  output  1  terminal count: high when state == all-ones and iw_up is high, or when state == 0 and iw_up is low. Registered; reflects the iw_up value sampled in the previous cycle.
- ow_wrap  output  1  one-cycle pulse in the cycle after a wrap transition (max->0 or 0->max).

Behaviour:
- Internal state: binary register B[p_WIDTH-1:0] and Gray register G; G == B ^ (B >> 1) holds at every clock edge.
- Priority per edge: iw_rst > iw_load > iw_en > hold.
- Reset: B=0, G=0, ow_tc=0, ow_wrap=0 on the first edge with iw_rst high. Reset mid-count discards the current state; no partial step occurs.
- Load: B <= Gray-to-binary(iwv_load_rbc), using a running XOR from MSB down; G <= iwv_load_rbc. iw_en is ignored in the load cycle. ow_wrap=0.
- Count, iw_en=1, iw_up=1:
  - B<max: B <= B+1.
  - B==max, p_WRAP=1: B <= 0 and ow_wrap=1.
  - B==max, p_WRAP=0: B holds, ow_wrap=0.
- Count, iw_en=1, iw_up=0:
  - B>0: B <= B-1.
  - B==0, p_WRAP=1: B <= max and ow_wrap=1.
  - B==0, p_WRAP=0: B holds.
- Hold, iw_en=0 and no load: B, G hold; ow_wrap=0.
- Latency: one cycle. Outputs reflect the step taken on the edge at which iw_en/iw_load was sampled.
- Every counting step changes exactly one bit of owv_rbc. Saturated holds change zero bits. Loads may change any number of bits.
- Width rule: all arithmetic is modulo 2^p_WIDTH; no carry out.
- p_WIDTH=1: owv_rbc == owv_bin and the counter toggles 0<->1.
- ow_tc is computed from the next state and the current iw_up, then registered. A direction change shows on ow_tc one cycle later.
- owv_bin and owv_rbc come directly from flops.

Test Plan (p_WIDTH=4 unless stated):
- Reset, then iw_en=1, iw_up=1 for 16 cycles:
  - owv_rbc sequence 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8 then 0.
  - ow_wrap=1 only on the cycle showing 0 after 8.
  - ow_tc=1 while owv_rbc=8.
  - Checker: popcount(rbc_prev ^ rbc)==1 on every step.
- From reset, one decrement with p_WRAP=1: owv_rbc=4'b1000, owv_bin=15, ow_wrap=1. Next decrement: owv_rbc=4'b1001, owv_bin=14, ow_wrap=0.
- iw_load=1, iwv_load_rbc=4'b1100 with iw_en=1 in the same cycle: next cycle owv_rbc=1100, owv_bin=1000, no extra step. Following increment: rbc=1101, bin=9.
- p_WRAP=0: load 4'b1000 (bin 15), then 3 increments: owv_rbc stays 1000, ow_wrap never asserts, ow_tc=1. Then iw_up=0 for one step: rbc=1001.
- Assert iw_rst together with iw_load and iw_en mid-count at bin 6: next cycle owv_rbc=0, owv_bin=0, ow_tc=0, ow_wrap=0.
- p_WIDTH=1: increments give rbc 0,1,0 with ow_wrap on the return to 0. Random 10k-cycle run at p_WIDTH=7: owv_bin == decode(owv_rbc) every cycle.

Source files
------------

// File: rtl/rbc_counter.sv
// Up/down counter whose state is held both as binary and as Reflected Binary (Gray) code.
// Loads arrive in Gray code; every output comes straight from a flop.
module rbc_counter #(
    parameter int p_WIDTH = 4,
    parameter int p_WRAP  = 1
) (
    input  logic               iw_clk,
    input  logic               iw_rst,
    input  logic               iw_en,
    input  logic               iw_up,
    input  logic               iw_load,
    input  logic [p_WIDTH-1:0] iwv_load_rbc,
    output logic [p_WIDTH-1:0] owv_rbc,
    output logic [p_WIDTH-1:0] owv_bin,
    output logic               ow_tc,
    output logic               ow_wrap
);

    localparam logic [p_WIDTH-1:0] lp_one = p_WIDTH'(1);
    localparam logic [p_WIDTH-1:0] lp_max = {p_WIDTH{1'b1}};

    logic [p_WIDTH-1:0] bin_q, bin_d;
    logic [p_WIDTH-1:0] rbc_q, rbc_d;
    logic               tc_q, tc_d;
    logic               wrap_q, wrap_d;
    logic [p_WIDTH-1:0] load_bin;

    // Each binary bit is the XOR of all Gray bits from the MSB down to it.
    genvar gi;
    generate
        for (gi = 0; gi < p_WIDTH; gi++) begin : g_load_decode
            assign load_bin[gi] = ^iwv_load_rbc[p_WIDTH-1:gi];
        end
    endgenerate

    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (iw_load) begin
            bin_d = load_bin;
        end else if (iw_en) begin
            if (iw_up) begin
                if (bin_q != lp_max) begin
                    bin_d = bin_q + lp_one;
                end else if (p_WRAP != 0) begin
                    bin_d  = '0;
                    wrap_d = 1'b1;
                end
            end else begin
                if (bin_q != '0) begin
                    bin_d = bin_q - lp_one;
                end else if (p_WRAP != 0) begin
                    bin_d  = lp_max;
                    wrap_d = 1'b1;
                end
            end
        end
        rbc_d = bin_d ^ (bin_d >> 1);
        if (iw_load) begin
            rbc_d = iwv_load_rbc;
        end
        // Terminal count looks at where the state is going, in the direction requested now.
        tc_d = iw_up ? (bin_d == lp_max) : (bin_d == '0);
    end

    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            bin_q  <= '0;
            rbc_q  <= '0;
            tc_q   <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            rbc_q  <= rbc_d;
            tc_q   <= tc_d;
            wrap_q <= wrap_d;
        end
    end

    assign owv_bin = bin_q;
    assign owv_rbc = rbc_q;
    assign ow_tc   = tc_q;
    assign ow_wrap = wrap_q;

endmodule
